// File: rtl/invaders_input_pkg.sv
// Shared types and defaults for the button-to-command input path.
// Build option: INPUT_AUTO_REPEAT_EN enables direction auto-repeat.
package invaders_input_pkg;

    // Per-direction hold/repeat state
    typedef enum logic [1:0] {
        DIR_IDLE   = 2'd0,
        DIR_DELAY  = 2'd1,
        DIR_REPEAT = 2'd2
    } dir_state_e;

    // Default width of every tick counter
    localparam int DEFAULT_CNT_W = 8;

endpackage

// File: rtl/hold_repeat_fsm.sv
// Press/auto-repeat pulse generator for one effective direction level.
// INPUT_AUTO_REPEAT_EN: full IDLE/DELAY/REPEAT; otherwise one pulse per press.
module hold_repeat_fsm
    import invaders_input_pkg::*;
#(
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 5,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic init,
    input  logic lvl,
    input  logic tick,
    output logic pulse
);

    logic prev_q;
    logic prev_d;
    logic pulse_q;
    logic pulse_d;
    logic rise;

    // The first cycle after reset only samples levels, so a held
    // button is never mistaken for a fresh press.
    assign rise  = lvl & ~prev_q & ~init;
    assign pulse = pulse_q;

`ifdef INPUT_AUTO_REPEAT_EN

    dir_state_e       state_q;
    dir_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    // Saturating tick count, never wraps
    always_comb begin
        cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end

    // Next state: release always wins, a tick on the press cycle is ignored
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = 1'b0;
        prev_d  = lvl;
        if (init || !lvl) begin
            state_d = DIR_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                DIR_IDLE: begin
                    if (rise) begin
                        pulse_d = 1'b1;
                        cnt_d   = '0;
                        state_d = DIR_DELAY;
                    end
                end
                DIR_DELAY: begin
                    if (tick) begin
                        if (cnt_inc == CNT_W'(REPEAT_DELAY)) begin
                            pulse_d = 1'b1;
                            cnt_d   = '0;
                            state_d = DIR_REPEAT;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                DIR_REPEAT: begin
                    if (tick) begin
                        if (cnt_inc == CNT_W'(REPEAT_PERIOD)) begin
                            pulse_d = 1'b1;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end
                end
                default: begin
                    state_d = DIR_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter, previous level and registered pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIR_IDLE;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

`else

    // Timing parameters and the tick only matter with auto-repeat
    localparam int unused_params = REPEAT_DELAY + REPEAT_PERIOD + CNT_W;
    logic unused_tick;
    assign unused_tick = tick;

    // One pulse per effective rising edge
    always_comb begin
        prev_d  = lvl;
        pulse_d = rise;
    end

    // Previous level and registered pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

`endif

endmodule

// File: rtl/input_event_gen.sv
// Turns debounced button levels into single-cycle game commands.
// Build option: INPUT_AUTO_REPEAT_EN enables direction auto-repeat.
module input_event_gen
    import invaders_input_pkg::*;
#(
    parameter int REPEAT_DELAY  = 20,
    parameter int REPEAT_PERIOD = 5,
    parameter int FIRE_COOLDOWN = 30,
    parameter int RESET_HOLD    = 60,
    parameter int CNT_W         = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic d_left,
    input  logic d_right,
    input  logic d_fire,
    input  logic d_reset,
    output logic move_left,
    output logic move_right,
    output logic fire,
    output logic fire_busy,
    output logic game_reset
);

    logic             init_q;
    logic             init_d;
    logic             l_eff;
    logic             r_eff;
    logic             fire_prev_q;
    logic             fire_prev_d;
    logic             fire_q;
    logic             fire_d;
    logic             busy_q;
    logic             busy_d;
    logic [CNT_W-1:0] fire_cnt_q;
    logic [CNT_W-1:0] fire_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q;
    logic [CNT_W-1:0] hold_cnt_d;
    logic             game_reset_q;
    logic             game_reset_d;

    // Holding both directions cancels them out
    assign l_eff = d_left & ~d_right;
    assign r_eff = d_right & ~d_left;

    assign fire       = fire_q;
    assign fire_busy  = busy_q;
    assign game_reset = game_reset_q;

    // Flag marking the first cycle after reset release
    always_comb begin
        init_d = 1'b0;
    end

    // Flag register, set while in reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_q <= 1'b1;
        end else begin
            init_q <= init_d;
        end
    end

    hold_repeat_fsm #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .CNT_W         (CNT_W)
    ) u_left (
        .clk   (clk),
        .rst   (rst),
        .init  (init_q),
        .lvl   (l_eff),
        .tick  (tick),
        .pulse (move_left)
    );

    hold_repeat_fsm #(
        .REPEAT_DELAY  (REPEAT_DELAY),
        .REPEAT_PERIOD (REPEAT_PERIOD),
        .CNT_W         (CNT_W)
    ) u_right (
        .clk   (clk),
        .rst   (rst),
        .init  (init_q),
        .lvl   (r_eff),
        .tick  (tick),
        .pulse (move_right)
    );

    // Fire: presses during cooldown are dropped, never queued
    always_comb begin
        fire_prev_d = d_fire;
        fire_d      = 1'b0;
        fire_cnt_d  = fire_cnt_q;
        if (!init_q) begin
            if (d_fire && !fire_prev_q && fire_cnt_q == '0) begin
                fire_d     = 1'b1;
                fire_cnt_d = CNT_W'(FIRE_COOLDOWN);
            end else if (tick && fire_cnt_q != '0) begin
                fire_cnt_d = fire_cnt_q - 1'b1;
            end
        end
        busy_d = (fire_cnt_d != '0);
    end

    // Game reset: count held ticks, pulse once, freeze until release
    always_comb begin
        hold_cnt_d   = hold_cnt_q;
        game_reset_d = 1'b0;
        if (!d_reset) begin
            hold_cnt_d = '0;
        end else if (!init_q && tick &&
                     hold_cnt_q != CNT_W'(RESET_HOLD)) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
            if (hold_cnt_d == CNT_W'(RESET_HOLD)) begin
                game_reset_d = 1'b1;
            end
        end
    end

    // Fire and reset-hold registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fire_prev_q  <= 1'b0;
            fire_q       <= 1'b0;
            busy_q       <= 1'b0;
            fire_cnt_q   <= '0;
            hold_cnt_q   <= '0;
            game_reset_q <= 1'b0;
        end else begin
            fire_prev_q  <= fire_prev_d;
            fire_q       <= fire_d;
            busy_q       <= busy_d;
            fire_cnt_q   <= fire_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            game_reset_q <= game_reset_d;
        end
    end

endmodule
